// File: rtl/fp_decode_pkg.sv
// Shared types and encodings for the RV F/D decode stage.
// Enum encodings follow fpnew so fp_dec_t can feed the FPU directly.
package fp_decode_pkg;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    operation_e  op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    roundmode_e  rm;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [4:0]  raddr_c;
    logic [4:0]  waddr;
    logic        fp_load;
    logic        fp_store;
    logic        mv_wx;
    logic        mv_xw;
    logic        fpu_op;
    logic        illegal;
  } fp_dec_t;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  // funct7 with fmt bits cleared (single-precision spelling)
  localparam logic [6:0] FADD_S    = 7'b0000000;
  localparam logic [6:0] FSUB_S    = 7'b0000100;
  localparam logic [6:0] FMUL_S    = 7'b0001000;
  localparam logic [6:0] FDIV_S    = 7'b0001100;
  localparam logic [6:0] FSQRT_S   = 7'b0101100;
  localparam logic [6:0] FSGNJ_S   = 7'b0010000;
  localparam logic [6:0] FMINMAX_S = 7'b0010100;
  localparam logic [6:0] FCMP_S    = 7'b1010000;
  localparam logic [6:0] FCVT_F2F  = 7'b0100000;
  localparam logic [6:0] FCVT_W_S  = 7'b1100000;
  localparam logic [6:0] FCVT_S_W  = 7'b1101000;
  localparam logic [6:0] FMV_X_W   = 7'b1110000;
  localparam logic [6:0] FMV_W_X   = 7'b1111000;

  // Instruction fmt field
  localparam logic [1:0] FMT_S = 2'b00;
  localparam logic [1:0] FMT_D = 2'b01;

  // Static rm 101/110 are reserved; dynamic rm needs a legal frm.
  function automatic logic rm_valid(input logic [2:0] rm, input logic [2:0] frm);
    logic ok;
    case (rm)
      3'b101, 3'b110: ok = 1'b0;
      3'b111:         ok = (frm <= 3'b100);
      default:        ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Map the 2-bit fmt field onto the FPU format; reserved codes collapse to FP32.
  function automatic fp_format_e fmt_decode(input logic [1:0] fmt);
    fp_format_e f;
    case (fmt)
      FMT_D:   f = FP64;
      default: f = FP32;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fp_decode_stage_comb.sv
// Pure combinational RV F/D decoder: instruction + frm -> fp_dec_t.
// Illegal encodings still produce a record, with every enable cleared.
module fp_decode_comb
  import fp_decode_pkg::*;
#(
  parameter int unsigned FLEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0] i_instr,
  input  logic [2:0]  i_frm,
  output fp_dec_t     o_dec
);

  localparam logic HAS_D   = (FLEN >= 64);
  localparam logic HAS_I64 = (XLEN >= 64);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rs2;
  logic [1:0] w_fmt;
  logic [6:0] w_f7_base;
  logic       w_fmt_ok;
  logic       w_rm_ok;
  roundmode_e w_rm_res;
  roundmode_e w_rm_raw;
  logic       w_ill;
  fp_dec_t    w_dec;

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_rs2     = i_instr[24:20];
  assign w_fmt     = i_instr[26:25];
  assign w_f7_base = {i_instr[31:27], 2'b00};
  assign w_fmt_ok  = (w_fmt == FMT_S) || ((w_fmt == FMT_D) && HAS_D);
  assign w_rm_ok   = rm_valid(w_funct3, i_frm);
  assign w_rm_raw  = roundmode_e'(w_funct3);
  assign w_rm_res  = (w_funct3 == 3'b111) ? roundmode_e'(i_frm) : w_rm_raw;

  // Field extraction, opcode decode and legality checks
  always_comb begin
    w_dec         = '0;
    w_ill         = 1'b0;
    w_dec.raddr_a = i_instr[19:15];
    w_dec.raddr_b = w_rs2;
    w_dec.waddr   = i_instr[11:7];
    w_dec.src_fmt = fmt_decode(w_fmt);
    w_dec.dst_fmt = fmt_decode(w_fmt);
    w_dec.rm      = w_rm_res;
    case (w_opcode)
      OPC_LOAD_FP, OPC_STORE_FP: begin
        w_dec.rm       = RNE;
        w_dec.fp_load  = (w_opcode == OPC_LOAD_FP);
        w_dec.fp_store = (w_opcode == OPC_STORE_FP);
        if (w_opcode == OPC_STORE_FP) begin
          w_dec.waddr = 5'd0;
        end else begin
          w_dec.raddr_b = 5'd0;
        end
        case (w_funct3)
          3'b010: begin
            w_dec.src_fmt = FP32;
            w_dec.dst_fmt = FP32;
          end
          3'b011: begin
            w_dec.src_fmt = FP64;
            w_dec.dst_fmt = FP64;
            w_ill         = !HAS_D;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        w_dec.op      = ((w_opcode == OPC_FMADD) || (w_opcode == OPC_FMSUB)) ? FMADD : FNMSUB;
        w_dec.op_mod  = (w_opcode == OPC_FMSUB) || (w_opcode == OPC_FNMADD);
        w_dec.raddr_c = i_instr[31:27];
        w_dec.fpu_op  = 1'b1;
        w_ill         = !w_fmt_ok || !w_rm_ok;
      end
      OPC_OP_FP: begin
        w_dec.fpu_op = 1'b1;
        case (w_f7_base)
          FADD_S, FSUB_S, FMUL_S, FDIV_S, FSQRT_S: begin
            case (w_f7_base)
              FSUB_S:  begin w_dec.op = ADD; w_dec.op_mod = 1'b1; end
              FMUL_S:  w_dec.op = MUL;
              FDIV_S:  w_dec.op = DIV;
              FSQRT_S: w_dec.op = SQRT;
              default: w_dec.op = ADD;
            endcase
            w_ill = !w_fmt_ok || !w_rm_ok || ((w_f7_base == FSQRT_S) && (w_rs2 != 5'd0));
          end
          FSGNJ_S: begin
            w_dec.op = SGNJ;
            w_dec.rm = w_rm_raw;
            w_ill    = !w_fmt_ok || (w_funct3 > 3'd2);
          end
          FMINMAX_S: begin
            w_dec.op = MINMAX;
            w_dec.rm = w_rm_raw;
            w_ill    = !w_fmt_ok || (w_funct3 > 3'd1);
          end
          FCMP_S: begin
            w_dec.op = CMP;
            w_dec.rm = w_rm_raw;
            w_ill    = !w_fmt_ok || (w_funct3 > 3'd2);
          end
          FCVT_F2F: begin
            // rs2 names the source format; same-format conversion is reserved
            w_dec.op      = F2F;
            w_dec.src_fmt = fmt_decode(w_rs2[1:0]);
            w_ill = !w_fmt_ok || !w_rm_ok || (w_rs2[4:1] != 4'd0) ||
                    (w_rs2[0] && !HAS_D) || (w_rs2[1:0] == w_fmt);
          end
          FCVT_W_S, FCVT_S_W: begin
            w_dec.op      = (w_f7_base == FCVT_W_S) ? F2I : I2F;
            w_dec.op_mod  = w_rs2[0];
            w_dec.int_fmt = w_rs2[1] ? INT64 : INT32;
            w_ill = !w_fmt_ok || !w_rm_ok || (w_rs2[4:2] != 3'd0) || (w_rs2[1] && !HAS_I64);
          end
          FMV_X_W, FMV_W_X: begin
            w_dec.rm = w_rm_raw;
            if ((w_f7_base == FMV_X_W) && (w_funct3 == 3'b001)) begin
              w_dec.op = CLASSIFY;
              w_ill    = !w_fmt_ok || (w_rs2 != 5'd0);
            end else begin
              // Register moves bypass the FPU datapath
              w_dec.fpu_op = 1'b0;
              w_dec.mv_xw  = (w_f7_base == FMV_X_W);
              w_dec.mv_wx  = (w_f7_base == FMV_W_X);
              w_ill = !w_fmt_ok || (w_funct3 != 3'b000) || (w_rs2 != 5'd0) ||
                      ((w_fmt == FMT_D) && !HAS_I64);
            end
          end
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_dec.fpu_op   = 1'b0;
      w_dec.fp_load  = 1'b0;
      w_dec.fp_store = 1'b0;
      w_dec.mv_wx    = 1'b0;
      w_dec.mv_xw    = 1'b0;
      w_dec.illegal  = 1'b1;
    end else begin
      w_dec.illegal  = 1'b0;
    end
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/fp_decode_stage.sv
// Registered F/D decode stage with a 1- or 2-entry skid buffer.
// Optional FP_DECODE_PERF_EN adds saturating decoded/illegal pop counters.
module fp_decode_stage
  import fp_decode_pkg::*;
#(
  parameter int unsigned FLEN       = 64,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [2:0]  frm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output fp_dec_t     dec_o
`ifdef FP_DECODE_PERF_EN
  ,
  output logic [31:0] dec_cnt_o,
  output logic [31:0] ill_cnt_o
`endif
);

  localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);

  fp_dec_t    w_dec;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;
  logic [1:0] r_count;
  logic       r_in_ready;
  logic       r_out_valid;
  fp_dec_t    r_head;
  fp_dec_t    r_tail;

  fp_decode_comb #(.FLEN(FLEN), .XLEN(XLEN)) u_comb (
    .i_instr (instr_i),
    .i_frm   (frm_i),
    .o_dec   (w_dec)
  );

  assign w_push      = in_valid_i && r_in_ready;
  assign w_pop       = r_out_valid && out_ready_i;
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign dec_o       = r_head;

  // Next occupancy from push/pop, flush empties the buffer
  always_comb begin
    w_count_nxt = r_count;
    if (flush_i) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Occupancy and registered handshake flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < DEPTH);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  // Head/tail storage: head drives dec_o, tail holds the second entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!flush_i) begin
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_head <= r_tail;
        end else if (w_push) begin
          r_head <= w_dec;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_head <= w_dec;
        end else begin
          r_tail <= w_dec;
        end
      end
    end
  end

`ifdef FP_DECODE_PERF_EN
  logic [31:0] r_dec_cnt;
  logic [31:0] r_ill_cnt;

  // Saturating pop counters; flushed cycles do not count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dec_cnt <= 32'd0;
      r_ill_cnt <= 32'd0;
    end else if (w_pop && !flush_i) begin
      if (r_dec_cnt != 32'hFFFF_FFFF) begin
        r_dec_cnt <= r_dec_cnt + 32'd1;
      end
      if (r_head.illegal && (r_ill_cnt != 32'hFFFF_FFFF)) begin
        r_ill_cnt <= r_ill_cnt + 32'd1;
      end
    end
  end

  assign dec_cnt_o = r_dec_cnt;
  assign ill_cnt_o = r_ill_cnt;
`endif

endmodule
